// File: rtl/spi_ram.sv
// Command-decoded single-port RAM behind the SPI slave: 10-bit words carry opcode[9:8] + payload[7:0].
// Optional address auto-increment on data commands is enabled by defining SPI_RAM_ADDR_AUTOINC_EN.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  logic [7:0]           mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic                 rd_armed_q, rd_armed_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 mem_we;

  op_e                  op;
  logic [ADDR_SIZE-1:0] addr_pl;

  assign op      = op_e'(din[9:8]);
  assign addr_pl = din[ADDR_SIZE-1:0];

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rd_armed_d = rd_armed_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    // A command on a reset edge is dropped, including any memory write.
    if (rx_valid && rst_n) begin
      unique case (op)
        OP_WR_ADDR: wr_addr_d = addr_pl;
        OP_WR_DATA: begin
          mem_we = 1'b1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
          wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
`endif
        end
        OP_RD_ADDR: begin
          rd_addr_d  = addr_pl;
          rd_armed_d = 1'b1;
        end
        OP_RD_DATA: begin
          if (rd_armed_q) begin
            dout_d     = mem[rd_addr_q];
            tx_valid_d = 1'b1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
            rd_addr_d  = rd_addr_q + ADDR_SIZE'(1);
`endif
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_armed_q <= 1'b0;
      dout_q     <= 8'h00;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_armed_q <= rd_armed_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Memory contents survive reset; only the write enable is reset-gated.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q] <= din[7:0];
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;

endmodule
